// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the unified-memory arbiter of the 5-stage core:
//   - FSM state encoding (legacy-compatible 2-bit constants)
//   - stall-vector bit positions, one per pipeline register/stage
//   - the three stall patterns the arbiter can emit
// Optional feature macro used by the arbiter: MEM_ARB_TIMEOUT_EN.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID     = 2;
  localparam int STALL_ID_EX  = 3;
  localparam int STALL_EX_MEM = 4;
  localparam int STALL_MEM_WB = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  // Fetch wait: freeze the front end (pc, if_id, id); later stages keep draining.
  localparam logic [5:0] STALL_IF   = (6'd1 << STALL_PC) | (6'd1 << STALL_IF_ID)
                                    | (6'd1 << STALL_ID);
  // Data wait: freeze everything up to and including ex_mem.
  localparam logic [5:0] STALL_MEM  = STALL_IF | (6'd1 << STALL_ID_EX)
                                    | (6'd1 << STALL_EX_MEM);

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
// Wait-state counter for the memory arbiter. Cleared when a transaction
// starts, counts every busy cycle without ram_ready, and flags expiry in the
// cycle that would be the TIMEOUT_CYCLES-th such cycle.
// Only present when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   i_start   in   a transaction is being granted this cycle
//   i_busy    in   arbiter is in FETCH or DATA
//   i_ready   in   memory completes the access this cycle
//   o_expire  out  abort the current access this cycle
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_expire
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_busy && !i_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of wait cycles already elapsed, so the current
  // one is the last allowed when it equals TIMEOUT_CYCLES-1.
  assign o_expire = i_busy && !i_ready && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between instruction fetch and the MEM stage.
// One transaction at a time over a ram_ready handshake; data accesses win
// over fetches; produces the pipeline stall vector.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a wait-state watchdog
// that aborts hung accesses and raises the sticky err_o flag.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_done)
//   if_done/if_rdata         fetch completion pulse and instruction
//   mem_req/we/addr/wdata/sel data request (held until mem_done)
//   mem_done/mem_rdata       data completion pulse and load data
//   flush                    redirect; suppresses the in-flight fetch result
//   ram_ce/we/addr/wdata/sel registered memory request
//   ram_rdata/ram_ready      memory response
//   stall_o                  6-bit stall vector (bit0 pc .. bit5 mem_wb)
//   err_o                    sticky timeout flag (0 without the watchdog)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_sel,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_sel,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic [5:0]        stall_o,
  output logic              err_o
);

  logic [1:0]        r_state;
  logic              r_ram_ce;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [3:0]        r_ram_sel;
  logic              r_if_done;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_mem_done;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_flush_seen;

  logic       w_mem_pend;
  logic       w_if_pend;
  logic       w_grant_mem;
  logic       w_grant_if;
  logic       w_busy;
  logic       w_expire;
  logic       w_complete;
  logic [5:0] w_stall;

  // A requester still shows req during its own done cycle (the pipeline
  // only advances at the next edge), so that request is already served.
  assign w_mem_pend  = mem_req && !r_mem_done;
  assign w_if_pend   = if_req && !r_if_done;
  assign w_grant_mem = (r_state == ST_IDLE) && w_mem_pend;
  assign w_grant_if  = (r_state == ST_IDLE) && !w_mem_pend && w_if_pend && !flush;
  assign w_busy      = (r_state == ST_FETCH) || (r_state == ST_DATA);
  assign w_complete  = w_busy && (ram_ready || w_expire);

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_start;
  logic r_err;

  assign w_start = w_grant_mem || w_grant_if;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_busy  (w_busy),
    .i_ready (ram_ready),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_expire         = 1'b0;
  assign err_o            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_ram_ce     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_sel    <= 4'h0;
      r_if_done    <= 1'b0;
      r_if_rdata   <= '0;
      r_mem_done   <= 1'b0;
      r_mem_rdata  <= '0;
      r_flush_seen <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_mem) begin
            r_state     <= ST_DATA;
            r_ram_ce    <= 1'b1;
            r_ram_we    <= mem_we;
            r_ram_addr  <= mem_addr;
            r_ram_wdata <= mem_wdata;
            r_ram_sel   <= mem_sel;
          end else if (w_grant_if) begin
            r_state      <= ST_FETCH;
            r_ram_ce     <= 1'b1;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= if_addr;
            r_ram_sel    <= 4'hF;
            r_flush_seen <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (flush) begin
            r_flush_seen <= 1'b1;
          end
          if (w_complete) begin
            r_state  <= ST_IDLE;
            r_ram_ce <= 1'b0;
            r_ram_we <= 1'b0;
            // A redirect seen at any point of the fetch kills its result;
            // the stale instruction must not reach if_id.
            if (!(flush || r_flush_seen)) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_expire ? '0 : ram_rdata;
            end
          end
        end
        ST_DATA: begin
          if (w_complete) begin
            r_state    <= ST_IDLE;
            r_ram_ce   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_mem_done <= 1'b1;
            // Stores return nothing meaningful; keep the last load value.
            if (!r_ram_we || w_expire) begin
              r_mem_rdata <= w_expire ? '0 : ram_rdata;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_ram_ce <= 1'b0;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_stall = STALL_NONE;
    if (mem_req && !r_mem_done) begin
      w_stall = STALL_MEM;
    end else if (if_req && !r_if_done && !flush) begin
      w_stall = STALL_IF;
    end
    // Writeback always retires; it is never frozen by memory waits.
    w_stall[STALL_MEM_WB] = 1'b0;
  end

  assign stall_o   = w_stall;
  assign ram_ce    = r_ram_ce;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_sel   = r_ram_sel;
  assign if_done   = r_if_done;
  assign if_rdata  = r_if_rdata;
  assign mem_done  = r_mem_done;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_sel = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        flush = 1'b0;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;
  logic [5:0]  stall_o;
  logic        err_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .flush(flush),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_sel(ram_sel), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stall_o(stall_o), .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory contents: BFM storage and reference model ----------
  logic [31:0] bmem    [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bfm_rd(input logic [31:0] a);
    if (bmem.exists(a >> 2)) return bmem[a >> 2];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
    return init_word(a);
  endfunction

  // ---------------- RAM BFM: >=0 fixed waits, -1 random 0..3, -2 never ready ----
  int bfm_cfg  = 0;
  bit bfm_busy = 1'b0;
  int bfm_left = 0;

  always @(posedge clk) begin
    if (rst && ram_ce && ram_ready) begin
      if (ram_we) bmem[ram_addr >> 2] = merge(bfm_rd(ram_addr), ram_wdata, ram_sel);
      bfm_busy = 1'b0;
    end
    #1;
    if (ram_ce) begin
      if (!bfm_busy) begin
        bfm_busy = 1'b1;
        bfm_left = (bfm_cfg == -1) ? int'($urandom_range(0, 3)) : bfm_cfg;
      end else if (bfm_left > 0) begin
        bfm_left--;
      end
      ram_ready = (bfm_cfg != -2) && (bfm_left == 0);
      ram_rdata = bfm_rd(ram_addr);
    end else begin
      bfm_busy  = 1'b0;
      ram_ready = 1'($urandom_range(0, 1));  // must be ignored while idle
      ram_rdata = $urandom;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
  } mexp_t;

  logic [31:0] if_q  [$];
  mexp_t       mem_q [$];
  logic [31:0] mon_if_exp;
  mexp_t       mon_mem_exp;

  always @(negedge clk) begin
    if (rst) begin
      if (if_done) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL if_done_unexpected: got pulse rdata=%0h expected no pulse", if_rdata);
        end else begin
          checks--;
          mon_if_exp = if_q.pop_front();
          check("if_rdata", 64'(if_rdata), 64'(mon_if_exp));
        end
      end
      if (mem_done) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_done_unexpected: got pulse rdata=%0h expected no pulse", mem_rdata);
        end else begin
          mon_mem_exp = mem_q.pop_front();
          if (mon_mem_exp.is_load) begin
            checks--;
            check("mem_rdata", 64'(mem_rdata), 64'(mon_mem_exp.data));
          end
        end
      end
    end
  end

  // ---------------- requester helpers ----------------
  task automatic push_fetch(input logic [31:0] a, input bit expect_done);
    if_addr = a;
    if_req  = 1'b1;
    if (expect_done) if_q.push_back(ref_rd(a));
  endtask

  task automatic push_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] sel, input bit expect_done);
    mexp_t e;
    mem_we = we; mem_addr = a; mem_wdata = wd; mem_sel = sel; mem_req = 1'b1;
    if (expect_done) begin
      if (we) begin
        ref_mem[a >> 2] = merge(ref_rd(a), wd, sel);
        e = '{is_load: 1'b0, data: 32'h0};
      end else begin
        e = '{is_load: 1'b1, data: ref_rd(a)};
      end
      mem_q.push_back(e);
    end
  endtask

  task automatic wait_if(output int lat);
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      seen = if_done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL if_done_timeout: got no pulse in %0d cycles expected a pulse", lat);
    end
    if_req = 1'b0;
  endtask

  task automatic wait_mem(output int lat);
    bit seen = 1'b0;
    lat = 0;
    while (!seen && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      seen = mem_done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL mem_done_timeout: got no pulse in %0d cycles expected a pulse", lat);
    end
    mem_req = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int lat;
    bmem[32'h100 >> 2]    = 32'h00500093;
    ref_mem[32'h100 >> 2] = 32'h00500093;

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("rst_ram_ce", 64'(ram_ce), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    check("rst_ram_sel", 64'(ram_sel), 64'd0);
    check("rst_if_done", 64'(if_done), 64'd0);
    check("rst_mem_done", 64'(mem_done), 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Fetch, zero wait states
    @(posedge clk); #1;
    bfm_cfg = 0;
    push_fetch(32'h100, 1'b1);
    #1 check("f0_stall_wait", 64'(stall_o), 64'b000111);
    @(posedge clk); #1;
    check("f0_ram_ce", 64'(ram_ce), 64'd1);
    check("f0_ram_addr", 64'(ram_addr), 64'h100);
    check("f0_ram_we", 64'(ram_we), 64'd0);
    check("f0_ram_sel", 64'(ram_sel), 64'hF);
    check("f0_stall_busy", 64'(stall_o), 64'b000111);
    @(posedge clk); #1;
    check("f0_if_done_edge2", 64'(if_done), 64'd1);
    check("f0_stall_done", 64'(stall_o), 64'b000000);
    if_req = 1'b0;

    // Simultaneous store + fetch: data wins
    @(posedge clk); #1;
    push_data(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1'b1);
    push_fetch(32'h104, 1'b1);
    #1 check("sim_stall_mem", 64'(stall_o), 64'b011111);
    @(posedge clk); #1;
    check("sim_ram_we", 64'(ram_we), 64'd1);
    check("sim_ram_sel", 64'(ram_sel), 64'b0011);
    check("sim_ram_addr", 64'(ram_addr), 64'h2000);
    check("sim_ram_wdata", 64'(ram_wdata), 64'hDEADBEEF);
    @(posedge clk); #1;
    check("sim_mem_done", 64'(mem_done), 64'd1);
    check("sim_if_not_done", 64'(if_done), 64'd0);
    check("sim_idle_gap", 64'(ram_ce), 64'd0);
    mem_req = 1'b0;
    #1 check("sim_stall_if", 64'(stall_o), 64'b000111);
    @(posedge clk); #1;
    check("sim_fetch_ce", 64'(ram_ce), 64'd1);
    check("sim_fetch_addr", 64'(ram_addr), 64'h104);
    check("sim_fetch_we", 64'(ram_we), 64'd0);
    wait_if(lat);
    check("sim_fetch_lat", 64'(lat), 64'd1);

    // Load with 3 wait states: ram_* stable, done 5 edges after sampling
    @(posedge clk); #1;
    bfm_cfg = 3;
    push_data(1'b0, 32'h2000, 32'h0, 4'hF, 1'b1);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mem_done) break;
      check("ws_ram_ce", 64'(ram_ce), 64'd1);
      check("ws_ram_addr", 64'(ram_addr), 64'h2000);
      check("ws_ram_we", 64'(ram_we), 64'd0);
    end
    mem_req = 1'b0;
    check("ws_latency", 64'(lat), 64'd5);

    // Flush in the second FETCH cycle
    @(posedge clk); #1;
    push_fetch(32'h200, 1'b0);
    @(posedge clk); #1;
    check("fl_ce", 64'(ram_ce), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    push_fetch(32'h300, 1'b1);
    #1 check("fl_stall", 64'(stall_o), 64'b000000);
    check("fl_addr_stable", 64'(ram_addr), 64'h200);
    @(posedge clk); #1;
    flush = 1'b0;
    wait_if(lat);
    check("fl_refetch_lat", 64'(lat), 64'd7);

    // Asynchronous reset in the middle of a data access
    @(posedge clk); #1;
    bfm_cfg = 5;
    push_data(1'b0, 32'h2004, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1;
    check("ar_ce_before", 64'(ram_ce), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_ce_async", 64'(ram_ce), 64'd0);
    check("ar_no_done", 64'(mem_done), 64'd0);
    check("ar_stall", 64'(stall_o), 64'b011111);
    mem_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    bfm_cfg = 0;
    repeat (2) @(posedge clk);
    #1;
    push_fetch(32'h108, 1'b1);
    wait_if(lat);
    check("ar_idle_after", 64'(lat), 64'd2);

    // Randomized concurrent traffic
    bfm_cfg = -1;
    fork
      begin
        int flat;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          push_fetch(32'($urandom_range(0, 1023)) << 2, 1'b1);
          wait_if(flat);
        end
      end
      begin
        int dlat;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          push_data(1'($urandom_range(0, 1)), 32'h2000 + (32'($urandom_range(0, 63)) << 2),
                    $urandom, 4'($urandom_range(1, 15)), 1'b1);
          wait_mem(dlat);
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;

`ifdef MEM_ARB_TIMEOUT_EN
    // Hung memory: watchdog aborts with zero data and sets err_o
    bfm_cfg = -2;
    begin
      mexp_t e;
      e = '{is_load: 1'b1, data: 32'h0};
      mem_we = 1'b0; mem_addr = 32'h2008; mem_sel = 4'hF; mem_req = 1'b1;
      mem_q.push_back(e);
    end
    wait_mem(lat);
    check("to_err_set", 64'(err_o), 64'd1);
    bfm_cfg = 0;
    repeat (4) @(posedge clk);
    #1 check("to_err_sticky", 64'(err_o), 64'd1);
`else
    check("err_tied_low", 64'(err_o), 64'd0);
`endif

    check("if_q_drained", 64'(if_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : global_bound
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish before bound");
    $fatal(1, "simulation bound exceeded");
  end

endmodule
